// File: rtl/palette_encoder.sv
// Nearest-colour search: maps an RGB444 pixel to the closest entry of a
// 16-entry programmable palette, one entry per clock. Optional macro: PALETTE_ENC_EARLY_EXIT_EN.
module palette_encoder #(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned INDEX_W     = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               pal_we,
  input  logic [INDEX_W-1:0] pal_addr,
  input  logic [11:0]        pal_data,
  output logic               pal_wr_drop,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [11:0]        in_rgb,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INDEX_W-1:0] out_index,
  output logic [5:0]         out_dist,
  output logic               out_exact
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t             r_state;
  logic [11:0]        r_pal [NUM_ENTRIES];
  logic [11:0]        r_pix;
  logic [INDEX_W-1:0] r_cnt;
  logic [5:0]         r_best_dist;
  logic [INDEX_W-1:0] r_best_idx;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [INDEX_W-1:0] r_out_index;
  logic [5:0]         r_out_dist;
  logic               r_out_exact;
  logic               r_drop;

  logic [11:0]        w_entry;
  logic [5:0]         w_dist;
  logic               w_better;
  logic [5:0]         w_new_dist;
  logic [INDEX_W-1:0] w_new_idx;
  logic               w_last;
  logic               w_finish;
  logic               w_wr_ok;

  function automatic logic [3:0] absdiff(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign w_entry    = r_pal[r_cnt];
  assign w_dist     = {2'b00, absdiff(r_pix[11:8], w_entry[11:8])}
                    + {2'b00, absdiff(r_pix[7:4],  w_entry[7:4])}
                    + {2'b00, absdiff(r_pix[3:0],  w_entry[3:0])};
  // Strict compare: a tie keeps the earlier (lower) index.
  assign w_better   = (w_dist < r_best_dist);
  assign w_new_dist = w_better ? w_dist : r_best_dist;
  assign w_new_idx  = w_better ? r_cnt  : r_best_idx;
  assign w_last     = (32'(r_cnt) == NUM_ENTRIES - 1);
`ifdef PALETTE_ENC_EARLY_EXIT_EN
  assign w_finish   = w_last || (w_dist == 6'd0);
`else
  assign w_finish   = w_last;
`endif
  assign w_wr_ok    = pal_we && (32'(pal_addr) < NUM_ENTRIES);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) r_pal[i] <= '0;
      r_drop <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (w_wr_ok) begin
        if (r_state == SEARCH) r_drop <= 1'b1;
        else                   r_pal[pal_addr] <= pal_data;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_pix       <= '0;
      r_cnt       <= '0;
      r_best_dist <= '1;
      r_best_idx  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_index <= '0;
      r_out_dist  <= '0;
      r_out_exact <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_pix       <= in_rgb;
            r_cnt       <= '0;
            r_best_dist <= '1;
            r_best_idx  <= '0;
            r_in_ready  <= 1'b0;
            r_state     <= SEARCH;
          end
        end
        SEARCH: begin
          r_best_dist <= w_new_dist;
          r_best_idx  <= w_new_idx;
          r_cnt       <= r_cnt + 1'b1;
          if (w_finish) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out_index <= w_new_idx;
            r_out_dist  <= w_new_dist;
            r_out_exact <= (w_new_dist == 6'd0);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_index   = r_out_index;
  assign out_dist    = r_out_dist;
  assign out_exact   = r_out_exact;
  assign pal_wr_drop = r_drop;

endmodule

// File: doc/palette_encoder.md
# palette_encoder

Reverse of the sprite palette lookup: takes a 12-bit RGB444 pixel and returns the 4-bit index of the nearest entry in a 16-entry programmable palette, plus the distance and an exact-match flag. It sits between the pixel source (camera/framebuffer capture path) and the on-chip sprite/index memories, so captured images are stored as 4-bit indices and redrawn through the existing palette lookup. The search is iterative, one palette entry per clock, with valid/ready handshakes on both sides.

## Interface
- NUM_ENTRIES, 16, palette depth; entries searched 0..NUM_ENTRIES-1
- INDEX_W, 4, index width; must satisfy 2**INDEX_W >= NUM_ENTRIES
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state including palette
- pal_we  in  1  palette write strobe
- pal_addr  in  INDEX_W  palette write address
- pal_data  in  12  palette write data {R[3:0],G[3:0],B[3:0]}
- pal_wr_drop  out  1  one-cycle pulse: a write was ignored (issued during SEARCH)
- in_valid  in  1  pixel available
- in_ready  out  1  block accepts a pixel
- in_rgb  in  12  pixel {R,G,B}
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_index  out  INDEX_W  nearest palette index
- out_dist  out  6  Manhattan distance of winner
- out_exact  out  1  out_dist == 0

## Operation
- FSM states: IDLE, SEARCH, DONE. Reset -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_rgb, clear entry counter, best_dist=63, best_idx=0 -> SEARCH.
- SEARCH: in_ready=0. Each cycle compare entry i: dist = |dR|+|dG|+|dB|, each abs diff 4 bits unsigned, sum 6 bits (max 45, no overflow). Update best if dist < best_dist (strict: ties keep lower index). After entry NUM_ENTRIES-1 -> DONE.
- DONE: out_valid=1; out_index/out_dist/out_exact held stable. On out_ready -> IDLE. No new pixel accepted in DONE (no overlap).
- Palette writes: applied at the clock edge when pal_we=1 in IDLE or DONE. In SEARCH the write is discarded and pal_wr_drop pulses the following cycle; palette content seen by a search is therefore constant.
- Writes to pal_addr >= NUM_ENTRIES ignored (no drop pulse).
- Reset mid-operation: immediate return to IDLE, search abandoned, no result emitted, all palette entries 12'h000.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, out_index=0, out_dist=0, out_exact=0, pal_wr_drop=0, palette all 12'h000.
- Accept at edge E0; entry i compared in cycle after E_i, committed at E_(i+1); DONE entered at E_NUM_ENTRIES. out_valid visible after edge 16 (NUM_ENTRIES=16).
- out_valid rises registered; result outputs registered, change only on DONE entry.
- out_ready sampled only in DONE; handshake edge returns to IDLE, in_ready=1 the next cycle. Minimum pixel period: NUM_ENTRIES+2 cycles.
- out_ready high before out_valid has no effect.

## Configuration
- PALETTE_ENC_EARLY_EXIT_EN defined: in SEARCH, dist==0 at entry k commits and enters DONE at edge E_(k+1); latency k+1 cycles. Exact match at entry 0 -> out_valid after 1 edge.
- Not defined: full scan always; latency fixed at NUM_ENTRIES edges regardless of match position. Result values identical in both builds (lowest index with minimum distance).

## Test plan
- Reset asserted mid-cycle (async), released -> in_ready=1, out_valid=0, out_index=0, out_dist=0, all palette reads 12'h000 via subsequent search.
- Load entry k = 12'h1B4+k*12'h111 (masked per nibble); pixel 12'h1B4 -> out_index=0, out_dist=0, out_exact=1; out_valid 16 edges after accept (2 edges... 1 edge with PALETTE_ENC_EARLY_EXIT_EN).
- Tie: entries 0 and 6 = 12'h1B4, others 12'hFFF; pixel 12'h1B4 -> out_index=0; pixel 12'h2B4 -> out_index=0, out_dist=1.
- Nearest: all entries 12'h000 except entry 5 = 12'hCCC; pixel 12'hFFF -> out_index=5, out_dist=9, out_exact=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid=1, outputs stable, in_ready=0; pal_we to entry 3 during DONE takes effect; raise out_ready -> in_ready=1 next cycle.
- pal_we during SEARCH -> pal_wr_drop pulses once, entry unchanged; Reset at 5th SEARCH cycle -> no out_valid, palette zeroed; then pixel 12'h123 -> out_index=0, out_dist=6.
